// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types, constants and helpers for the 3x3 streaming
//               convolution engine (conv3x3_stream).
//               - coef_t / acc_t are sized for the default build
//                 (WORD_SIZE=8, COEF_W=8). Parametrised instances size their
//                 own locals from the same formulas.
//               - KERNEL_TAPS : number of kernel taps (3x3).
//               - CENTER_TAP  : tap holding 1.0 in the identity kernel.
//               - identity_coef() : identity kernel value for one tap.
//               - saturate()      : clamp a signed value into an unsigned
//                                   word of a given width.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_COEF_W    = 8;
  localparam int DEF_FRAC_BITS = 4;

  localparam int KERNEL_TAPS   = 9;
  localparam int CENTER_TAP    = 4;

  // Signed fixed-point coefficient and 9-term accumulator (4 guard bits
  // above the WORD_SIZE+COEF_W+1 product width).
  typedef logic signed [DEF_COEF_W-1:0]                 coef_t;
  typedef logic signed [DEF_WORD_SIZE+DEF_COEF_W+4:0]   acc_t;

  // Identity kernel: 1.0 (in the coefficient's fixed-point format) at the
  // centre tap, zero elsewhere.
  function automatic int identity_coef(input int tap, input int frac_bits);
    return (tap == CENTER_TAP) ? (1 << frac_bits) : 0;
  endfunction

  // Clamp a signed value to [0, 2^width-1]; caller keeps the low width bits.
  function automatic logic [63:0] saturate(input logic signed [63:0] val,
                                           input int                 width);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< width) - 64'sd1;
    if (val < 64'sd0) begin
      return '0;
    end else if (val > max_v) begin
      return max_v;
    end else begin
      return val;
    end
  endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_line_buffer
// Description : Two-row pixel delay of depth ROW_SIZE. Addressed by the
//               current column; while i_en is high each edge writes the new
//               pixel into row-1 storage and moves the old row-1 value into
//               row-2 storage at the same column.
// Ports       : clk, rst_n (async, active-low)
//               i_en    - shift enable (one accepted pixel)
//               i_addr  - current column
//               i_din   - incoming pixel (row r)
//               o_row1  - pixel at (r-1, col)
//               o_row2  - pixel at (r-2, col)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540,
  parameter int ADDR_W    = $clog2(ROW_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [WORD_SIZE-1:0] i_din,
  output logic [WORD_SIZE-1:0] o_row1,
  output logic [WORD_SIZE-1:0] o_row2
);

  logic [WORD_SIZE-1:0] r_mem1 [0:ROW_SIZE-1];
  logic [WORD_SIZE-1:0] r_mem2 [0:ROW_SIZE-1];

  // Read before write: outputs show the previous rows at this column.
  assign o_row1 = r_mem1[i_addr];
  assign o_row2 = r_mem2[i_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW_SIZE; i++) begin
        r_mem1[i] <= '0;
        r_mem2[i] <= '0;
      end
    end else if (i_en) begin
      r_mem1[i_addr] <= i_din;
      r_mem2[i_addr] <= r_mem1[i_addr];
    end
  end

endmodule : conv_line_buffer
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_stream
// Description : Streaming 3x3 convolution with a runtime-loadable signed
//               fixed-point kernel and valid/ready flow control.
//               Raster pixels enter one per handshake; valid windows
//               (no padding) leave two edges after their bottom-right pixel
//               is accepted, saturated to WORD_SIZE bits.
//               Build option: define CONV_ABS_EN to take |sum| before the
//               shift and clamp (edge-magnitude kernels).
// Ports       : clk, rst_n      - clock, async active-low reset
//               in_valid/ready  - input handshake, in_pixel raster data
//               coef_we/addr/data - kernel write port (index 0..8, row-major,
//                                 0 = oldest row, oldest column)
//               out_valid/ready - output handshake
//               out_pixel       - convolved, saturated result
//               out_last        - final output of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540,
  parameter int COL_SIZE  = 360,
  parameter int COEF_W    = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_pixel,
  input  logic                 coef_we,
  input  logic [3:0]           coef_addr,
  input  logic [COEF_W-1:0]    coef_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_last
);

  localparam int c_COL_W  = $clog2(ROW_SIZE);
  localparam int c_ROW_W  = $clog2(COL_SIZE);
  localparam int c_PROD_W = WORD_SIZE + COEF_W + 1;
  localparam int c_ACC_W  = WORD_SIZE + COEF_W + 5;

  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(ROW_SIZE - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(COL_SIZE - 1);
  localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
  localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

  // ---------------------------------------------------------------------
  // Flow control: every stage moves together when the output register is
  // empty or being drained.
  // ---------------------------------------------------------------------
  logic r_out_valid;
  logic w_advance;
  logic w_accept;

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;
  assign w_accept  = in_valid && w_advance;

  // ---------------------------------------------------------------------
  // Raster position of the pixel currently offered.
  // ---------------------------------------------------------------------
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic               w_emit;
  logic               w_frame_end;

  assign w_emit      = (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
  assign w_frame_end = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Line buffers feeding the right-hand column of the window.
  // ---------------------------------------------------------------------
  logic [WORD_SIZE-1:0] w_row1;
  logic [WORD_SIZE-1:0] w_row2;

  conv_line_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .ROW_SIZE  (ROW_SIZE),
    .ADDR_W    (c_COL_W)
  ) u_line_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_accept),
    .i_addr (r_col),
    .i_din  (in_pixel),
    .o_row1 (w_row1),
    .o_row2 (w_row2)
  );

  // ---------------------------------------------------------------------
  // 3x3 window: [row][col], row 0 = r-2, col 0 = c-2 (tap index 3*row+col).
  // ---------------------------------------------------------------------
  logic [WORD_SIZE-1:0] r_win [0:2][0:2];
  logic                 r_win_valid;
  logic                 r_win_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_row2;
      r_win[1][2] <= w_row1;
      r_win[2][2] <= in_pixel;
    end
  end

  // ---------------------------------------------------------------------
  // Kernel registers; writes are independent of the stream handshake.
  // ---------------------------------------------------------------------
  logic signed [COEF_W-1:0] r_coef [0:KERNEL_TAPS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        r_coef[t] <= COEF_W'(identity_coef(t, FRAC_BITS));
      end
    end else if (coef_we) begin
      // Addresses 9..15 match no tap and are dropped.
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        if (coef_addr == 4'(t)) begin
          r_coef[t] <= coef_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Products: unsigned pixel promoted to signed, both operands extended to
  // the full product width so the multiply is exact.
  // ---------------------------------------------------------------------
  logic signed [c_PROD_W-1:0] w_prod [0:KERNEL_TAPS-1];
  logic signed [c_PROD_W-1:0] r_prod [0:KERNEL_TAPS-1];
  logic                       r_prod_valid;
  logic                       r_prod_last;

  for (genvar t = 0; t < KERNEL_TAPS; t++) begin : g_tap
    logic signed [c_PROD_W-1:0] w_pix_ext;
    logic signed [c_PROD_W-1:0] w_coef_ext;
    assign w_pix_ext  = c_PROD_W'($signed({1'b0, r_win[t/3][t%3]}));
    assign w_coef_ext = c_PROD_W'(r_coef[t]);
    assign w_prod[t]  = w_pix_ext * w_coef_ext;
  end

  // ---------------------------------------------------------------------
  // Sum, optional magnitude, floor shift and clamp.
  // ---------------------------------------------------------------------
  logic signed [c_ACC_W-1:0] w_sum;
  logic signed [c_ACC_W-1:0] w_mag;
  logic signed [c_ACC_W-1:0] w_shift;
  logic signed [63:0]        w_sum64;

  always_comb begin
    w_sum = '0;
    for (int t = 0; t < KERNEL_TAPS; t++) begin
      w_sum = w_sum + c_ACC_W'(r_prod[t]);
    end
  end

`ifdef CONV_ABS_EN
  assign w_mag = (w_sum < 0) ? -w_sum : w_sum;
`else
  assign w_mag = w_sum;
`endif

  assign w_shift = w_mag >>> FRAC_BITS;
  assign w_sum64 = 64'(w_shift);

  // ---------------------------------------------------------------------
  // Pipeline registers: window valid -> products -> output.
  // ---------------------------------------------------------------------
  logic [WORD_SIZE-1:0] r_out_pixel;
  logic                 r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_prod_valid <= 1'b0;
      r_prod_last  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_last   <= 1'b0;
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        r_prod[t] <= '0;
      end
    end else if (w_advance) begin
      // A bubble leaves the window untouched but must not re-emit it.
      r_win_valid  <= w_accept && w_emit;
      r_win_last   <= w_accept && w_frame_end;
      r_prod_valid <= r_win_valid;
      r_prod_last  <= r_win_last;
      for (int t = 0; t < KERNEL_TAPS; t++) begin
        r_prod[t] <= w_prod[t];
      end
      r_out_valid  <= r_prod_valid;
      r_out_last   <= r_prod_valid && r_prod_last;
      if (r_prod_valid) begin
        r_out_pixel <= WORD_SIZE'(saturate(w_sum64, WORD_SIZE));
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_last  = r_out_last;

endmodule : conv3x3_stream
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_stream
// Description : Self-checking bench for conv3x3_stream on a 5x4 frame.
//               Expected outputs are computed from the driven image and the
//               bench's own kernel copy and queued on acceptance; a monitor
//               pops and compares each output transfer.
//               Honours CONV_ABS_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

  localparam int c_W    = 8;
  localparam int c_COLS = 5;   // ROW_SIZE
  localparam int c_ROWS = 4;   // COL_SIZE
  localparam int c_CW   = 8;
  localparam int c_FRAC = 4;
  localparam int c_NPIX = c_COLS * c_ROWS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [c_W-1:0]  in_pixel;
  logic            coef_we;
  logic [3:0]      coef_addr;
  logic [c_CW-1:0] coef_data;
  logic            out_valid;
  logic            out_ready;
  logic [c_W-1:0]  out_pixel;
  logic            out_last;

  always #5 clk = ~clk;

  conv3x3_stream #(
    .WORD_SIZE (c_W),
    .ROW_SIZE  (c_COLS),
    .COL_SIZE  (c_ROWS),
    .COEF_W    (c_CW),
    .FRAC_BITS (c_FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  exp_t     sb_q [$];
  exp_t     mon_e;
  int       coef_m [9];
  int       img [c_ROWS][c_COLS];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc = 0;
  int       acc22_cyc = 0;
  int       first_valid_cyc = 0;
  bit       seen_first = 1'b0;
  int       n_last = 0;
  bit       held = 1'b0;
  logic [7:0] held_pix;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: floor-shifted, clamped 3x3 dot product.
  function automatic exp_t model(input int r, input int c);
    int s;
    int q;
    exp_t e;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s += img[r-2+i][c-2+j] * coef_m[3*i+j];
      end
    end
`ifdef CONV_ABS_EN
    if (s < 0) s = -s;
`endif
    q = s / (1 << c_FRAC);
    if (s < 0 && (s % (1 << c_FRAC)) != 0) q = q - 1;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    e.pix  = q[7:0];
    e.last = (r == c_ROWS-1) && (c == c_COLS-1);
    return e;
  endfunction

  // Output monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!seen_first) begin
          seen_first      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("unexpected_out", 32'd1, 32'd0);
          end else begin
            mon_e = sb_q.pop_front();
            check_eq("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
            check_eq("out_last", 32'(out_last), 32'(mon_e.last));
          end
          if (out_last) n_last++;
          held = 1'b0;
        end else begin
          check_eq("stall_in_ready", 32'(in_ready), 32'd0);
          if (held) check_eq("stall_stable", 32'(out_pixel), 32'(held_pix));
          held     = 1'b1;
          held_pix = out_pixel;
        end
      end
    end
  end

  task automatic set_identity_model();
    for (int t = 0; t < 9; t++) coef_m[t] = (t == 4) ? (1 << c_FRAC) : 0;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 8'(val);
    @(posedge clk); #1;
    coef_we   = 1'b0;
    if (addr < 9) coef_m[addr] = val;
  endtask

  task automatic drive_pixel(input int r, input int c, input int pix, input int gap_pct);
    bit ok;
    int g;
    g = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && g < 8) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b1;
    in_pixel = 8'(pix);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (r == 2 && c == 2) acc22_cyc = cyc;
      if (r >= 2 && c >= 2) sb_q.push_back(model(r, c));
    end
  endtask

  // mode 0: 5r+c, mode 1: constant fillv, mode 2: random
  task automatic send_frame(input int mode, input int fillv, input int gap_pct, input int stop_idx);
    int pix;
    for (int r = 0; r < c_ROWS; r++) begin
      for (int c = 0; c < c_COLS; c++) begin
        if (r * c_COLS + c < stop_idx) begin
          pix = (mode == 0) ? (5*r + c) : (mode == 1) ? fillv : int'($urandom_range(255));
          img[r][c] = pix;
          drive_pixel(r, c, pix, gap_pct);
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int exp_last);
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq({"drain_", tag}, 32'(sb_q.size()), 32'd0);
    check_eq({"last_cnt_", tag}, 32'(n_last), 32'(exp_last));
    n_last = 0;
    sb_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    set_identity_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_pixel", 32'(out_pixel), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Identity kernel on the 5r+c ramp: 6,7,8,11,12,13.
    seen_first = 1'b0;
    send_frame(0, 0, 0, c_NPIX);
    drain("ramp", 1);
    check_eq("latency", 32'(first_valid_cyc - acc22_cyc), 32'd2);

    // All ones kernel on saturated white.
    for (int t = 0; t < 9; t++) write_coef(t, 16);
    write_coef(12, 99);
    send_frame(1, 255, 0, c_NPIX);
    drain("sat", 1);

    // 2/16 kernel on 64: 72.
    for (int t = 0; t < 9; t++) write_coef(t, 2);
    send_frame(1, 64, 0, c_NPIX);
    drain("avg", 1);

    // Negative centre: clamps to 0 (or magnitude 100).
    for (int t = 0; t < 9; t++) write_coef(t, (t == 4) ? -16 : 0);
    send_frame(1, 100, 0, c_NPIX);
    drain("neg", 1);

    // Random kernel and image with a 5-cycle output stall.
    for (int t = 0; t < 9; t++) write_coef(t, int'($urandom_range(40)) - 12);
    fork
      send_frame(2, 0, 0, c_NPIX);
      begin
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
          @(posedge clk); #1;
          k++;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("stall", 1);

    // Two back-to-back identity frames with 50% input bubbles.
    for (int t = 0; t < 9; t++) write_coef(t, (t == 4) ? 16 : 0);
    send_frame(0, 0, 50, c_NPIX);
    send_frame(2, 0, 50, c_NPIX);
    drain("gaps", 2);

    // Mid-frame reset while offering (2,3) with a non-identity kernel.
    write_coef(4, 32);
    write_coef(0, 5);
    send_frame(0, 0, 0, 2*c_COLS + 3);
    in_valid = 1'b1;
    in_pixel = 8'd13;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    held = 1'b0;
    set_identity_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send_frame(0, 0, 0, c_NPIX);
    drain("after_rst", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_conv3x3_stream
`default_nettype wire
